video_tint: RTL and testbench

VIDEO_TINT -- requirements
Module: video_tint

---
 rtl/video_tint.sv | 183 ++++++++++++++++++
 tb/tb_video_tint.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_tint.sv
// video_tint: two-stage monochrome-to-colour tint pipeline with delayed syncs.
// Stage 1 captures luminance (expanded to 8 bits) and timing; stage 2 applies
// the tint selected at the last VSync rising edge and blanks outside DE.
// Optional feature: define VIDEO_TINT_FADE_EN for a post-reset fade-in that
// brightens by FADE_STEP on each VSync rising edge.
module video_tint #(
  parameter int IN_W      = 8,
  parameter int FADE_STEP = 8
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic [IN_W-1:0] video,
  input  logic            HBlank,
  input  logic            VBlank,
  input  logic            HSync,
  input  logic            VSync,
  input  logic [2:0]      mode,
  input  logic [23:0]     custom_rgb,
  output logic [7:0]      VGA_R,
  output logic [7:0]      VGA_G,
  output logic [7:0]      VGA_B,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_DE,
  output logic            ce_out
);

  localparam logic [2:0] MODE_RED    = 3'd1;
  localparam logic [2:0] MODE_GREEN  = 3'd2;
  localparam logic [2:0] MODE_BLUE   = 3'd3;
  localparam logic [2:0] MODE_AMBER  = 3'd4;
  localparam logic [2:0] MODE_CUSTOM = 3'd5;

  // Out-of-range parameters would silently build a wrong datapath.
  if (IN_W < 1 || IN_W > 8 || FADE_STEP < 1 || FADE_STEP > 255) begin : g_param_check
    $error("video_tint: IN_W must be 1..8 and FADE_STEP 1..255");
  end

  logic [7:0]  v_exp;
  logic [7:0]  v1_reg;
  logic        hs1_reg, vs1_reg, de1_reg;
  logic [2:0]  mode_q_reg;
  logic [23:0] custom_q_reg;
  logic        vsync_rise;
  logic [7:0]  r_next, g_next, b_next;
  logic [7:0]  r_reg, g_reg, b_reg;
  logic        hs_reg, vs_reg, de_reg, ce_out_reg;

  // MSB-first replication: output bit 7-gi takes input bit IN_W-1-(gi mod IN_W),
  // so a narrow code spans the full 0x00..0xFF range.
  for (genvar gi = 0; gi < 8; gi++) begin : g_expand
    assign v_exp[7-gi] = video[IN_W-1-(gi%IN_W)];
  end

  // Edge is judged against the VSync of the last pixel that entered stage 1.
  assign vsync_rise = ce_pix & VSync & ~vs1_reg;

  function automatic logic [7:0] scale8(input logic [7:0] a, input logic [7:0] b);
    return 8'((16'(a) * 16'(b)) >> 8);
  endfunction

  // Stage 1: capture expanded luminance and raw timing on each pixel enable
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      v1_reg  <= '0;
      hs1_reg <= 1'b0;
      vs1_reg <= 1'b0;
      de1_reg <= 1'b0;
    end else if (ce_pix) begin
      v1_reg  <= v_exp;
      hs1_reg <= HSync;
      vs1_reg <= VSync;
      de1_reg <= ~(HBlank | VBlank);
    end
  end

  // Tint selection follows inputs during reset, then changes only at frame start
  always_ff @(posedge clk_sys) begin
    if (reset || vsync_rise) begin
      mode_q_reg   <= mode;
      custom_q_reg <= custom_rgb;
    end
  end

`ifdef VIDEO_TINT_FADE_EN
  logic [7:0] fade_lvl_reg;
  logic [8:0] fade_sum;

  assign fade_sum = {1'b0, fade_lvl_reg} + 9'(FADE_STEP);

  // Fade level ramps up once per frame and saturates at full brightness
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fade_lvl_reg <= '0;
    end else if (vsync_rise) begin
      fade_lvl_reg <= fade_sum[8] ? 8'hFF : fade_sum[7:0];
    end
  end

  function automatic logic [7:0] fade8(input logic [7:0] c, input logic [7:0] lvl);
    return 8'((16'(c) * (16'(lvl) + 16'd1)) >> 8);
  endfunction
`endif

  // Stage-2 colour: tint the stage-1 value, apply fade if built in, blank outside DE
  always_comb begin
    r_next = v1_reg;
    g_next = v1_reg;
    b_next = v1_reg;
    case (mode_q_reg)
      MODE_RED: begin
        g_next = '0;
        b_next = '0;
      end
      MODE_GREEN: begin
        r_next = '0;
        b_next = '0;
      end
      MODE_BLUE: begin
        r_next = '0;
        g_next = '0;
      end
      MODE_AMBER: begin
        g_next = 8'((10'(v1_reg) * 10'd3) >> 2);
        b_next = '0;
      end
      MODE_CUSTOM: begin
        r_next = scale8(v1_reg, custom_q_reg[23:16]);
        g_next = scale8(v1_reg, custom_q_reg[15:8]);
        b_next = scale8(v1_reg, custom_q_reg[7:0]);
      end
      default: ;  // white, including reserved codes 6 and 7
    endcase
`ifdef VIDEO_TINT_FADE_EN
    r_next = fade8(r_next, fade_lvl_reg);
    g_next = fade8(g_next, fade_lvl_reg);
    b_next = fade8(b_next, fade_lvl_reg);
`endif
    if (!de1_reg) begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
    end
  end

  // Stage 2: register colour together with the stage-1 timing
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_reg  <= '0;
      g_reg  <= '0;
      b_reg  <= '0;
      hs_reg <= 1'b0;
      vs_reg <= 1'b0;
      de_reg <= 1'b0;
    end else if (ce_pix) begin
      r_reg  <= r_next;
      g_reg  <= g_next;
      b_reg  <= b_next;
      hs_reg <= hs1_reg;
      vs_reg <= vs1_reg;
      de_reg <= de1_reg;
    end
  end

  // ce_out marks the cycle right after stage 2 has taken a new pixel
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_out_reg <= 1'b0;
    end else begin
      ce_out_reg <= ce_pix;
    end
  end

  assign VGA_R  = r_reg;
  assign VGA_G  = g_reg;
  assign VGA_B  = b_reg;
  assign VGA_HS = hs_reg;
  assign VGA_VS = vs_reg;
  assign VGA_DE = de_reg;
  assign ce_out = ce_out_reg;

endmodule

// File: tb/tb_video_tint.sv
// tb_video_tint: scoreboard bench for video_tint. Two instances (IN_W=8 and
// IN_W=4) share one stimulus stream; expected colours come from a plain
// arithmetic model of the tint rules and are checked whenever ce_out pulses.
`timescale 1ns/1ps
module tb_video_tint;

  localparam int STEP = 64;
`ifdef VIDEO_TINT_FADE_EN
  localparam int FADE_INIT = 0;
`else
  localparam int FADE_INIT = 255;  // no fade: identical to full brightness
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [7:0]  video = 8'h00;
  logic        HBlank = 1'b0, VBlank = 1'b0, HSync = 1'b0, VSync = 1'b0;
  logic [2:0]  mode = 3'd1;
  logic [23:0] custom_rgb = 24'h804000;

  logic [7:0] r8, g8, b8, r4, g4, b4;
  logic       hs8, vs8, de8, ce8, hs4, vs4, de4, ce4;

  always #5 clk_sys = ~clk_sys;

  video_tint #(.IN_W(8), .FADE_STEP(STEP)) u_dut8 (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .video(video),
    .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
    .mode(mode), .custom_rgb(custom_rgb),
    .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
    .VGA_HS(hs8), .VGA_VS(vs8), .VGA_DE(de8), .ce_out(ce8)
  );

  video_tint #(.IN_W(4), .FADE_STEP(STEP)) u_dut4 (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .video(video[7:4]),
    .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
    .mode(mode), .custom_rgb(custom_rgb),
    .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
    .VGA_HS(hs4), .VGA_VS(vs4), .VGA_DE(de4), .ce_out(ce4)
  );

  typedef struct {
    int r, g, b, r4, g4, b4;
    bit hs, vs, de;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // reference model state: selection latched at the latest VSync rise
  int m_mode, m_cust, m_fade, m_prev_vs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // tint rules written as plain integer arithmetic
  function automatic void tint(input int v, input int md, input int cust, input int fade,
                               input bit de, output int r, output int g, output int b);
    int cr, cg, cb;
    cr = (cust >> 16) & 255;
    cg = (cust >> 8) & 255;
    cb = cust & 255;
    case (md)
      1: begin r = v; g = 0; b = 0; end
      2: begin r = 0; g = v; b = 0; end
      3: begin r = 0; g = 0; b = v; end
      4: begin r = v; g = (v * 3) / 4; b = 0; end
      5: begin r = (v * cr) / 256; g = (v * cg) / 256; b = (v * cb) / 256; end
      default: begin r = v; g = v; b = v; end
    endcase
    r = (r * (fade + 1)) / 256;
    g = (g * (fade + 1)) / 256;
    b = (b * (fade + 1)) / 256;
    if (!de) begin r = 0; g = 0; b = 0; end
  endfunction

  function automatic exp_t zero_entry();
    exp_t e;
    e.r = 0; e.g = 0; e.b = 0; e.r4 = 0; e.g4 = 0; e.b4 = 0;
    e.hs = 0; e.vs = 0; e.de = 0;
    return e;
  endfunction

  task automatic model_reset();
    sb.delete();
    sb.push_back(zero_entry());  // first enable after reset emits the cleared stage 1
    m_mode = int'(mode);
    m_cust = int'(custom_rgb);
    m_fade = FADE_INIT;
    m_prev_vs = 0;
  endtask

  // one pixel enable after 'gap' idle clocks; expected output pushed to scoreboard
  task automatic pix(input int gap, input int v, input bit hb, input bit vb,
                     input bit hs, input bit vs, input int md, input int cust);
    exp_t e;
    repeat (gap) begin
      @(negedge clk_sys);
      ce_pix = 1'b0;
    end
    @(negedge clk_sys);
    video = 8'(v); HBlank = hb; VBlank = vb; HSync = hs; VSync = vs;
    mode = 3'(md); custom_rgb = 24'(cust); ce_pix = 1'b1;
    if (vs && m_prev_vs == 0) begin
      m_mode = md;
      m_cust = cust;
      m_fade = (m_fade + STEP > 255) ? 255 : m_fade + STEP;
    end
    m_prev_vs = vs;
    e.hs = hs; e.vs = vs; e.de = !(hb || vb);
    tint(v, m_mode, m_cust, m_fade, e.de, e.r, e.g, e.b);
    tint(((v >> 4) & 15) * 17, m_mode, m_cust, m_fade, e.de, e.r4, e.g4, e.b4);
    sb.push_back(e);
  endtask

  task automatic vrise(input int md, input int cust);
    pix(1, 0, 1'b0, 1'b1, 1'b0, 1'b0, md, cust);
    pix(1, 0, 1'b0, 1'b1, 1'b0, 1'b1, md, cust);
    pix(1, 0, 1'b0, 1'b1, 1'b0, 1'b0, md, cust);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    ce_pix = 1'($urandom_range(0, 1));
    @(negedge clk_sys);
    reset = 1'b0;
    ce_pix = 1'b0;
    model_reset();
  endtask

  // monitor: reset clears outputs, ce_out pops the scoreboard, otherwise outputs hold
  bit         rst_prev = 1'b1;
  logic [26:0] last_out = '0;

  always @(posedge clk_sys) rst_prev <= reset;

  always @(negedge clk_sys) begin
    exp_t e;
    if (rst_prev) begin
      chk("reset_rgb", {8'h0, r8, g8, b8}, 32'h0);
      chk("reset_sync", {hs8, vs8, de8, ce8}, 32'h0);
    end else if (ce8) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("out t=%0t R=%02h G=%02h B=%02h HS=%0b VS=%0b DE=%0b | R4=%02h G4=%02h B4=%02h",
                 $time, r8, g8, b8, hs8, vs8, de8, r4, g4, b4);
        chk("r8", r8, e.r);
        chk("g8", g8, e.g);
        chk("b8", b8, e.b);
        chk("sync8", {hs8, vs8, de8}, {e.hs, e.vs, e.de});
        chk("r4", r4, e.r4);
        chk("g4", g4, e.g4);
        chk("b4", b4, e.b4);
        chk("sync4", {hs4, vs4, de4}, {e.hs, e.vs, e.de});
      end
    end else begin
      chk("hold", {r8, g8, b8, hs8, vs8, de8}, last_out);
    end
    last_out = {r8, g8, b8, hs8, vs8, de8};
  end

  initial begin
    int md, cust;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    model_reset();

    // red at every 4th clock, syncs toggling alongside the data
    for (int i = 0; i < 4; i++)
      pix(3, 'hA5, 1'b0, 1'b0, 1'(i & 1), 1'b0, 1, 'h804000);
    // white frame; a blue request mid-frame must wait for the next VSync
    vrise(0, 'h804000);
    for (int i = 0; i < 3; i++)
      pix(3, 'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 'h804000);
    vrise(3, 'h804000);
    pix(1, 'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3, 'h804000);
    pix(1, 'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3, 'h804000);
    // custom tint, then horizontal blanking forces black
    vrise(5, 'h804000);
    pix(1, 'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 5, 'h804000);
    pix(1, 'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 5, 'h804000);
    // amber, then a one-cycle reset mid-line
    vrise(4, 'h804000);
    pix(1, 'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4, 'h804000);
    pix(0, 'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 4, 'h804000);
    do_reset();
    for (int i = 0; i < 3; i++)
      pix(0, 'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4, 'h804000);
    // reserved mode codes behave as white
    vrise(7, 'h804000);
    pix(0, 'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 7, 'h804000);

    // randomized frames: 16x10 raster, random gaps, mode/colour changes, rare resets
    md = 0;
    cust = int'($urandom) & 'hFFFFFF;
    for (int f = 0; f < 10; f++) begin
      for (int y = 0; y < 10; y++) begin
        for (int x = 0; x < 16; x++) begin
          if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 7);
          if ($urandom_range(0, 19) == 0) cust = int'($urandom) & 'hFFFFFF;
          if ($urandom_range(0, 399) == 0) do_reset();
          pix($urandom_range(0, 2), int'($urandom_range(0, 255)), 1'(x >= 12), 1'(y >= 8),
              1'(x == 13 || x == 14), 1'(y == 9), md, cust);
        end
      end
    end

    @(negedge clk_sys);
    ce_pix = 1'b0;
    repeat (5) @(negedge clk_sys);
    // only the last pixel, still sitting in stage 1, has not been presented
    chk("sb_drain", sb.size(), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
